// File: rtl/arb_req_frontend.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_frontend
// Description : Request front end for a 4-way arbiter. Each of four clients
//               pushes command words into its own FIFO. While a FIFO holds
//               data, its req_n is raised to the arbiter. When gnt_n arrives
//               the head word is moved into a single registered output slot,
//               tagged with its source index. The slot uses a valid/ready
//               handshake toward the shared downstream resource.
// Ports       : clk, rst (sync, active-high)
//               in_valid_n / in_data_n / in_ready_n : client n push interface
//               req_n / gnt_n                       : arbiter interface
//               out_valid / out_data / out_src / out_ready : output slot
//               multi_gnt_err                       : sticky multi-grant flag
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_frontend #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_valid_3,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    output logic              in_ready_0,
    output logic              in_ready_1,
    output logic              in_ready_2,
    output logic              in_ready_3,
    output logic              req_0,
    output logic              req_1,
    output logic              req_2,
    output logic              req_3,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic              gnt_3,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready,
    output logic              multi_gnt_err
);

    localparam int c_DEPTH = 2 ** PTR_W;

    logic [3:0]             w_in_valid;
    logic [3:0][DATA_W-1:0] w_in_data;
    logic [3:0]             w_gnt;
    logic [3:0]             w_in_ready;
    logic [3:0]             w_nonempty;
    logic [3:0]             w_push;
    logic [3:0]             w_pop;
    logic [3:0][DATA_W-1:0] w_head;
    logic [3:0]             w_gnt_ok;
    logic [1:0]             w_sel;
    logic                   w_sel_ok;
    logic                   w_slot_free;
    logic                   w_multi_gnt;

    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic [1:0]             r_out_src;
    logic                   r_multi_gnt_err;

    assign w_in_valid = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
    assign w_in_data  = {in_data_3, in_data_2, in_data_1, in_data_0};
    assign w_gnt      = {gnt_3, gnt_2, gnt_1, gnt_0};

    // ------------------------------------------------------------------
    // Per-client FIFOs
    // ------------------------------------------------------------------
    for (genvar n = 0; n < 4; n++) begin : g_fifo
        logic [DATA_W-1:0] r_mem [c_DEPTH];
        logic [PTR_W-1:0]  r_wptr;
        logic [PTR_W-1:0]  r_rptr;
        logic [PTR_W:0]    r_cnt;

        // Count never exceeds DEPTH, so its MSB alone marks "full".
        assign w_in_ready[n] = ~r_cnt[PTR_W];
        assign w_nonempty[n] = (r_cnt != '0);
        assign w_push[n]     = w_in_valid[n] & w_in_ready[n];
        assign w_head[n]     = r_mem[r_rptr];

        // Contents are intentionally left unreset; pointers/count gate them.
        always_ff @(posedge clk) begin
            if (w_push[n] && !rst) begin
                r_mem[r_wptr] <= w_in_data[n];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[n]) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[n]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push[n], w_pop[n]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pop selection: lowest-index granted FIFO that actually has data.
    // Grants to empty FIFOs are ignored (a registered arbiter may lag).
    // ------------------------------------------------------------------
    assign w_gnt_ok    = w_gnt & w_nonempty;
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_multi_gnt = ((w_gnt & (w_gnt - 4'd1)) != 4'd0);

    always_comb begin
        w_sel    = 2'd0;
        w_sel_ok = 1'b0;
        for (int n = 3; n >= 0; n--) begin
            if (w_gnt_ok[n]) begin
                w_sel    = 2'(n);
                w_sel_ok = 1'b1;
            end
        end
    end

    assign w_pop = (w_sel_ok && w_slot_free) ? (4'b0001 << w_sel) : 4'b0000;

    // ------------------------------------------------------------------
    // Output slot and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_src       <= 2'd0;
            r_multi_gnt_err <= 1'b0;
        end else begin
            if (w_pop != 4'b0000) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head[w_sel];
                r_out_src   <= w_sel;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_multi_gnt) begin
                r_multi_gnt_err <= 1'b1;
            end
        end
    end

    assign in_ready_0    = w_in_ready[0];
    assign in_ready_1    = w_in_ready[1];
    assign in_ready_2    = w_in_ready[2];
    assign in_ready_3    = w_in_ready[3];
    assign req_0         = w_nonempty[0];
    assign req_1         = w_nonempty[1];
    assign req_2         = w_nonempty[2];
    assign req_3         = w_nonempty[3];
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_src       = r_out_src;
    assign multi_gnt_err = r_multi_gnt_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_req_frontend
// Description : Self-checking bench for arb_req_frontend. A queue-based
//               model tracks each client FIFO and the output slot; a compare
//               process checks every output on each falling edge. Directed
//               scenarios add literal expectations, followed by random
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_req_frontend;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] in_data [4];
    logic [3:0] gnt;
    logic       out_ready;

    logic [3:0] in_ready;
    logic [3:0] req;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       multi_gnt_err;

    int checks = 0;
    int errors = 0;

    arb_req_frontend #(.DATA_W(8), .PTR_W(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_0   (in_valid[0]),
        .in_valid_1   (in_valid[1]),
        .in_valid_2   (in_valid[2]),
        .in_valid_3   (in_valid[3]),
        .in_data_0    (in_data[0]),
        .in_data_1    (in_data[1]),
        .in_data_2    (in_data[2]),
        .in_data_3    (in_data[3]),
        .in_ready_0   (in_ready[0]),
        .in_ready_1   (in_ready[1]),
        .in_ready_2   (in_ready[2]),
        .in_ready_3   (in_ready[3]),
        .req_0        (req[0]),
        .req_1        (req[1]),
        .req_2        (req[2]),
        .req_3        (req[3]),
        .gnt_0        (gnt[0]),
        .gnt_1        (gnt[1]),
        .gnt_2        (gnt[2]),
        .gnt_3        (gnt[3]),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .multi_gnt_err(multi_gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one queue per client plus the output slot.
    // ------------------------------------------------------------------
    logic [7:0] q [4][$];
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_src;
    logic       m_err;
    logic       armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) q[n].delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_src   = 2'd0;
            m_err   = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            bit acc [4];
            int sel;
            for (int n = 0; n < 4; n++) acc[n] = in_valid[n] && (q[n].size() < 4);
            sel = -1;
            for (int n = 3; n >= 0; n--) if (gnt[n] && q[n].size() != 0) sel = n;
            if ($countones(gnt) >= 2) m_err = 1'b1;
            if (sel >= 0 && (!m_valid || out_ready)) begin
                m_data  = q[sel].pop_front();
                m_src   = 2'(sel);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            for (int n = 0; n < 4; n++) if (acc[n]) q[n].push_back(in_data[n]);
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (armed) begin
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("cyc_in_ready_%0d", n), 32'(in_ready[n]), 32'(q[n].size() < 4));
                chk($sformatf("cyc_req_%0d", n), 32'(req[n]), 32'(q[n].size() != 0));
            end
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_out_data", 32'(out_data), 32'(m_data));
            chk("cyc_out_src", 32'(out_src), 32'(m_src));
            chk("cyc_multi_gnt_err", 32'(multi_gnt_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 4'b0;
        gnt       = 4'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) in_data[n] = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_err", 32'(multi_gnt_err), 32'd0);

        // Single word on client 0
        in_valid[0] = 1'b1; in_data[0] = 8'hA1;
        tick();
        in_valid[0] = 1'b0;
        chk("t1_req0", 32'(req[0]), 32'd1);
        gnt[0] = 1'b1; out_ready = 1'b1;
        tick();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA1);
        chk("t1_out_src", 32'(out_src), 32'd0);
        chk("t1_req0_low", 32'(req[0]), 32'd0);
        gnt[0] = 1'b0;
        tick();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // Fill client 2 past depth, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[2] = 1'b1; in_data[2] = 8'(8'h10 + i);
            tick();
            if (i == 3) chk("t2_full", 32'(in_ready[2]), 32'd0);
        end
        in_valid[2] = 1'b0;
        gnt[2] = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_data", 32'(out_data), 32'(8'h10 + i));
            chk("t2_src", 32'(out_src), 32'd2);
        end
        tick();
        chk("t2_empty_req", 32'(req[2]), 32'd0);
        chk("t2_no_0x14", 32'(out_valid), 32'd0);
        // Streaming second fill crosses the pointer wrap
        for (int i = 0; i < 6; i++) begin
            in_valid[2] = 1'b1; in_data[2] = 8'(8'h20 + i);
            tick();
            if (i > 0) chk("t2_stream", 32'(out_data), 32'(8'h20 + i - 1));
        end
        in_valid[2] = 1'b0;
        tick();
        chk("t2_stream_last", 32'(out_data), 32'h25);
        gnt[2] = 1'b0;
        tick();

        // Back-pressure on client 1
        out_ready = 1'b0;
        in_valid[1] = 1'b1; in_data[1] = 8'h31; tick();
        in_data[1] = 8'h32; tick();
        in_valid[1] = 1'b0;
        gnt[1] = 1'b1;
        tick();
        chk("t3_first", 32'(out_data), 32'h31);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_data", 32'(out_data), 32'h31);
            chk("t3_hold_req", 32'(req[1]), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_release", 32'(out_data), 32'h32);
        gnt[1] = 1'b0;
        tick();

        // Push/pop on client 3 at count 2, then a late grant
        in_valid[3] = 1'b1; in_data[3] = 8'h51; tick();
        in_data[3] = 8'h52; tick();
        in_data[3] = 8'h53; gnt[3] = 1'b1;
        tick();
        in_valid[3] = 1'b0;
        chk("t5_pop0", 32'(out_data), 32'h51);
        tick();
        chk("t5_pop1", 32'(out_data), 32'h52);
        tick();
        chk("t5_pop2", 32'(out_data), 32'h53);
        tick();
        chk("t5_late_gnt_valid", 32'(out_valid), 32'd0);
        chk("t5_late_gnt_err", 32'(multi_gnt_err), 32'd0);
        gnt[3] = 1'b0;

        // Multiple grants
        in_valid[1] = 1'b1; in_data[1] = 8'h41;
        in_valid[3] = 1'b1; in_data[3] = 8'h43;
        tick();
        in_valid = 4'b0;
        gnt = 4'b1010;
        tick();
        chk("t4_err", 32'(multi_gnt_err), 32'd1);
        chk("t4_src", 32'(out_src), 32'd1);
        chk("t4_data", 32'(out_data), 32'h41);
        gnt = 4'b0000;
        tick();
        chk("t4_sticky", 32'(multi_gnt_err), 32'd1);
        gnt = 4'b1000;
        tick();
        chk("t4_src3", 32'(out_src), 32'd3);
        gnt = 4'b0000;
        tick();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 8'(8'h61 + i);
            tick();
        end
        in_valid[0] = 1'b0;
        gnt[0] = 1'b1;
        tick();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        gnt[0] = 1'b0;
        rst = 1'b1; in_valid[0] = 1'b1;
        tick();
        rst = 1'b0; in_valid[0] = 1'b0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_req0", 32'(req[0]), 32'd0);
        chk("t6_ready0", 32'(in_ready[0]), 32'd1);
        chk("t6_err", 32'(multi_gnt_err), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = 4'($urandom);
            for (int n = 0; n < 4; n++) in_data[n] = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 5)      gnt = 4'b0001 << $urandom_range(0, 3);
            else if (r <= 7) gnt = 4'b0000;
            else             gnt = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle();
        rst = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_req_frontend.md
Name: arb_req_frontend

Overview:
- Request front end for the 4-way arbiter (req_0..3 / gnt_0..3, clk, rst).
- Buffers commands from four clients in per-client FIFOs and drives req_n to the arbiter while FIFO n holds data.
- On gnt_n, pops the head of FIFO n into a single registered output slot, tagged with its source index, for the shared downstream resource (valid/ready).

Parameters:
- DATA_W, 8, width of each client command word
- PTR_W, 2, FIFO pointer width; FIFO depth DEPTH = 2**PTR_W (default 4)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid_0..in_valid_3  input  1 each  client n offers a command
- in_data_0..in_data_3  input  DATA_W each  client n command word
- in_ready_0..in_ready_3  output  1 each  FIFO n can accept (count_n < DEPTH)
- req_0..req_3  output  1 each  request to arbiter (FIFO n non-empty)
- gnt_0..gnt_3  input  1 each  grant from arbiter, expected one-hot or zero
- out_valid  output  1  output slot holds a command
- out_data  output  DATA_W  command in output slot
- out_src  output  2  index of client that supplied out_data
- out_ready  input  1  downstream accepts output slot
- multi_gnt_err  output  1  sticky: more than one gnt seen high in one cycle

Behaviour:
- Reset, synchronous, active-high. On any rising edge with rst=1:
  - all FIFO read/write pointers and counts cleared (count width PTR_W+1)
  - out_valid=0, out_data=0, out_src=0, multi_gnt_err=0
  - FIFO contents are not cleared
  - in_valid pushes during rst are dropped
- Combinational outputs:
  - req_n = (count_n != 0); req_n=0 in the cycle after reset
  - in_ready_n = (count_n < DEPTH)
- Push: when in_valid_n && in_ready_n, in_data_n is written at wptr_n. wptr_n wraps modulo DEPTH; count_n increments.
- Full FIFO: in_ready_n=0, so no push that cycle, even if the same cycle pops.
  - No full-bypass; the client retries next cycle.
- Empty FIFO plus push: data stored only, with no bypass to the output.
  - req_n rises on the next cycle, giving a first-beat latency of 1 cycle to req.
- Output slot free: slot_free = !out_valid || out_ready.
- Pop selection: sel = lowest n with gnt_n && count_n != 0.
  - A gnt on an empty FIFO is ignored. This is normal, since a registered arbiter grant can lag the pop by one cycle.
- Pop: if a valid sel exists and slot_free, then at the clock edge:
  - out_data <= head of FIFO sel, out_src <= sel, out_valid <= 1
  - rptr_sel advances with wrap; count_sel decrements
- Pop and push on the same FIFO in one cycle (not full): count is unchanged and both pointers advance.
  - Push and pop on an empty FIFO cannot coincide, since pop requires count != 0.
- Drain: if out_ready && out_valid and no pop this cycle, out_valid <= 0.
- Back-pressure: out_valid && !out_ready holds out_data and out_src stable. No pop occurs even with gnt high, so the FIFO keeps its data and req stays high.
- Throughput: with out_ready=1 held and a grant held, one word per cycle streams from the granted FIFO.
- multi_gnt_err: set when two or more gnt_n are high in the same cycle; cleared only by rst.
  - Selection still follows lowest-index among granted non-empty FIFOs.
- Reset mid-operation: FIFO words and the output slot are discarded, and req_n drops the cycle after reset.
- Ordering: per-client FIFO order is preserved. No ordering is defined across clients; order follows the grant sequence.

Test Plan:
- Reset, then push 0xA1 on client 0 -> req_0=1 one cycle after push. With gnt_0=1 and out_ready=1: out_valid=1, out_data=0xA1, out_src=0 next edge; req_0=0 after.
- Push 5 words 0x10..0x14 on client 2 with no gnt -> in_ready_2=0 after 4 accepted, 0x14 rejected. Grant and drain -> outputs 0x10..0x13 in order, out_src=2, wrap verified on a second fill.
- Hold out_ready=0 with out_valid=1 and gnt_1 high with FIFO 1 non-empty -> out_data stable, count_1 unchanged, req_1 stays 1. Release out_ready -> next word appears next edge.
- gnt_1 and gnt_3 high together, both non-empty -> multi_gnt_err=1 (sticky), out_src=1. Err stays 1 until rst.
- Push on client 3 in the same cycle as a pop from client 3 (count 2) -> count stays 2 and data order is preserved. A one-cycle-late gnt_3 after the FIFO empties -> no output and no error.
- Assert rst with 3 words queued in FIFO 0 and out_valid=1 -> next edge out_valid=0, req_0=0, in_ready_0=1, multi_gnt_err=0.
